// File: rtl/ol_sequencer_pkg.sv
// Shared types and list-entry encoding for the PVR ISP object-list sequencer.
// Imported by the entry decoder and the sequencer top.
package pvr_ol_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_ISSUE,
      ST_DRAW,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      KIND_PRIM,
      KIND_LINK,
      KIND_EOL,
      KIND_RSVD
   } entry_kind_t;

   // bit31 clear marks a triangle strip; otherwise [31:29] is the opcode
   localparam int STRIP_BIT = 31;
   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 29;
   localparam int EOL_BIT   = 28;

   localparam logic [2:0] OP_TRI_ARRAY  = 3'b100;
   localparam logic [2:0] OP_QUAD_ARRAY = 3'b101;
   localparam logic [2:0] OP_RESERVED   = 3'b110;
   localparam logic [2:0] OP_LINK       = 3'b111;

   localparam int PRIM_ADDR_MSB = 20;
   localparam int LINK_MSB      = 23;
   localparam int LINK_LSB      = 2;

endpackage

// File: rtl/ol_sequencer_if.sv
// VRAM port and ISP parser handshake between the sequencer (master) and
// the VRAM/parser side (slave).
interface ol_sequencer_if;
   logic        vram_rd;
   logic [23:0] vram_addr;
   logic [31:0] vram_din;
   logic        isp_vram_rd;
   logic [23:0] isp_vram_addr;
   logic        isp_grant;
   logic [31:0] opb_word;
   logic [23:0] poly_addr;
   logic        render_poly;
   logic        poly_drawn;

   modport master (
      output vram_rd, vram_addr, isp_grant, opb_word, poly_addr, render_poly,
      input  vram_din, isp_vram_rd, isp_vram_addr, poly_drawn
   );

   modport slave (
      input  vram_rd, vram_addr, isp_grant, opb_word, poly_addr, render_poly,
      output vram_din, isp_vram_rd, isp_vram_addr, poly_drawn
   );
endinterface

// File: rtl/ol_entry_decode.sv
// Combinational classifier for one object-list word: kind, primitive
// parameter address and link target.
module ol_entry_decode
   import pvr_ol_pkg::*;
(
   input  logic [31:0]  entry,
   input  logic [23:0]  param_base,
   output entry_kind_t  kind,
   output logic [23:0]  prim_addr,
   output logic [23:0]  link_target
);

   logic [2:0] opcode;
   logic       unused_bits;

   assign opcode      = entry[OP_MSB:OP_LSB];
   // bits 27:24 carry no information the walker needs
   assign unused_bits = ^entry[27:24];

   always_comb begin
      // NOTE: default assignment first so every path drives kind and no latch is inferred.
      kind = KIND_RSVD;
      if (!entry[STRIP_BIT]) begin
         kind = KIND_PRIM;
      end else begin
         case (opcode)
            OP_TRI_ARRAY, OP_QUAD_ARRAY: kind = KIND_PRIM;
            OP_LINK:                     kind = entry[EOL_BIT] ? KIND_EOL : KIND_LINK;
            OP_RESERVED:                 kind = KIND_RSVD;
            default:                     kind = KIND_RSVD;
         endcase
      end
   end

   assign prim_addr   = param_base + {1'b0, entry[PRIM_ADDR_MSB:0], 2'b00};
   assign link_target = {entry[LINK_MSB:LINK_LSB], 2'b00};

endmodule

// File: rtl/ol_sequencer.sv
// Walks one tile's object list, launching the ISP parser per primitive and
// lending it the shared VRAM read port while it draws.
module ol_sequencer
   import pvr_ol_pkg::*;
#(
   parameter int MAX_ENTRIES = 4096,
   parameter int TIMEOUT     = 1024
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [23:0]   ol_base,
   input  logic [23:0]   param_base,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [15:0]   prim_count,
   ol_sequencer_if.master bus
);

   localparam int ENT_W = $clog2(MAX_ENTRIES + 1);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_t            state;
   logic [23:0]       cur;
   logic [ENT_W-1:0]  ent_cnt;
   logic [ENT_W-1:0]  ent_next;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [TMO_W-1:0]  tmo_next;
   entry_kind_t       kind;
   logic [23:0]       prim_addr;
   logic [23:0]       link_target;

   ol_entry_decode u_decode (
      .entry       (bus.vram_din),
      .param_base  (param_base),
      .kind        (kind),
      .prim_addr   (prim_addr),
      .link_target (link_target)
   );

   assign ent_next        = ent_cnt + ENT_W'(1);
   assign tmo_next        = tmo_cnt + TMO_W'(1);
   assign busy            = (state != ST_IDLE);
   assign done            = (state == ST_DONE);
   assign bus.render_poly = (state == ST_ISSUE);
   assign bus.isp_grant   = (state == ST_DRAW);

   // The parser's strobe only reaches VRAM while it owns the port.
   always_comb begin
      bus.vram_rd   = 1'b0;
      bus.vram_addr = cur;
      case (state)
         ST_FETCH: bus.vram_rd = 1'b1;
         ST_DRAW: begin
            bus.vram_rd   = bus.isp_vram_rd;
            bus.vram_addr = bus.isp_vram_addr;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         cur          <= '0;
         ent_cnt      <= '0;
         tmo_cnt      <= '0;
         error        <= 1'b0;
         prim_count   <= '0;
         bus.opb_word <= '0;
         bus.poly_addr <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_FETCH;
                  cur        <= ol_base;
                  ent_cnt    <= '0;
                  error      <= 1'b0;
                  prim_count <= '0;
               end
            end
            ST_FETCH: state <= ST_DECODE;
            ST_DECODE: begin
               ent_cnt <= ent_next;
               // Entry limit guards against cyclic lists and wins over the decode.
               if (ent_next == ENT_W'(MAX_ENTRIES)) begin
                  error <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  case (kind)
                     KIND_PRIM: begin
                        bus.opb_word  <= bus.vram_din;
                        bus.poly_addr <= prim_addr;
                        cur           <= cur + 24'd4;
                        state         <= ST_ISSUE;
                     end
                     KIND_LINK: begin
                        cur   <= link_target;
                        state <= ST_FETCH;
                     end
                     KIND_EOL: state <= ST_DONE;
                     default: begin
                        cur   <= cur + 24'd4;
                        state <= ST_FETCH;
                     end
                  endcase
               end
            end
            ST_ISSUE: begin
               tmo_cnt <= '0;
               state   <= ST_DRAW;
            end
            ST_DRAW: begin
               if (bus.poly_drawn) begin
                  if (prim_count != 16'hFFFF) prim_count <= prim_count + 16'd1;
                  state <= ST_FETCH;
               end else if (tmo_next == TMO_W'(TIMEOUT)) begin
                  error <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  tmo_cnt <= tmo_next;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ol_sequencer.sv
// Directed bench for ol_sequencer: VRAM model, simple parser model and
// per-scenario tasks with hand-computed expectations.
module tb_ol_sequencer;

   logic        clock;
   logic        reset;
   logic        start;
   logic [23:0] ol_base;
   logic [23:0] param_base;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] prim_count;

   ol_sequencer_if bus();

   ol_sequencer #(.MAX_ENTRIES(8), .TIMEOUT(16)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .ol_base    (ol_base),
      .param_base (param_base),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .prim_count (prim_count),
      .bus        (bus.master)
   );

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   logic [31:0] mem [logic [23:0]];
   logic [23:0] fetch_q [$];
   int          render_cnt = 0;
   logic [23:0] last_poly;
   logic [31:0] last_opb;

   int   parser_delay;
   int   pd_cnt;
   logic pd_model;
   logic pd_extra;

   assign bus.poly_drawn = pd_model | pd_extra;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   // VRAM: data returns the cycle after the strobe
   always @(posedge clock) begin
      if (bus.vram_rd) bus.vram_din <= mem.exists(bus.vram_addr) ? mem[bus.vram_addr] : 32'h0;
   end

   // Parser: answers parser_delay cycles after render_poly; 0 means never
   always @(posedge clock) begin
      if (reset) begin
         pd_cnt   <= 0;
         pd_model <= 1'b0;
      end else begin
         pd_model <= 1'b0;
         if (bus.render_poly && parser_delay > 1) pd_cnt <= parser_delay - 1;
         else if (pd_cnt == 1) begin
            pd_model <= 1'b1;
            pd_cnt   <= 0;
         end else if (pd_cnt > 1) pd_cnt <= pd_cnt - 1;
      end
   end

   always @(negedge clock) begin
      if (bus.vram_rd && !bus.isp_grant) fetch_q.push_back(bus.vram_addr);
      if (bus.render_poly) begin
         render_cnt = render_cnt + 1;
         last_poly  = bus.poly_addr;
         last_opb   = bus.opb_word;
      end
   end

   task automatic load_list1();
      mem.delete();
      mem[24'h1000] = 32'h0000_0010;
      mem[24'h1004] = 32'hF000_0000;
      ol_base    = 24'h1000;
      param_base = 24'h200000;
   endtask

   // Returns at the falling edge of the first FETCH cycle.
   task automatic do_start();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clock);
         if (bus.isp_grant) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passes++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else passes++;
      checks++; if (error !== 1'b0) $display("FAIL reset_error got %0b want 0", error); else passes++;
      checks++; if (prim_count !== 16'h0) $display("FAIL reset_prim_count got %0h want 0", prim_count); else passes++;
      checks++; if (bus.render_poly !== 1'b0) $display("FAIL reset_render got %0b want 0", bus.render_poly); else passes++;
      checks++; if (bus.isp_grant !== 1'b0) $display("FAIL reset_grant got %0b want 0", bus.isp_grant); else passes++;
      checks++; if (bus.vram_rd !== 1'b0) $display("FAIL reset_vram_rd got %0b want 0", bus.vram_rd); else passes++;
      checks++; if (bus.vram_addr !== 24'h0) $display("FAIL reset_vram_addr got %0h want 0", bus.vram_addr); else passes++;
      checks++; if (bus.opb_word !== 32'h0) $display("FAIL reset_opb got %0h want 0", bus.opb_word); else passes++;
      checks++; if (bus.poly_addr !== 24'h0) $display("FAIL reset_poly_addr got %0h want 0", bus.poly_addr); else passes++;
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_single_prim();
      int r0;
      bit ok;
      load_list1();
      parser_delay = 5;
      r0 = render_cnt;
      do_start();
      checks++; if (busy !== 1'b1) $display("FAIL single_busy got %0b want 1", busy); else passes++;
      checks++; if ({bus.vram_rd, bus.vram_addr} !== {1'b1, 24'h1000})
         $display("FAIL single_fetch got rd=%0b addr=%0h want rd=1 addr=1000", bus.vram_rd, bus.vram_addr); else passes++;
      @(negedge clock);
      checks++; if (bus.render_poly !== 1'b0) $display("FAIL single_decode_render got %0b want 0", bus.render_poly); else passes++;
      @(negedge clock);
      checks++; if (bus.render_poly !== 1'b1) $display("FAIL single_issue_render got %0b want 1", bus.render_poly); else passes++;
      checks++; if (bus.opb_word !== 32'h0000_0010) $display("FAIL single_opb got %0h want 10", bus.opb_word); else passes++;
      checks++; if (bus.poly_addr !== 24'h200040) $display("FAIL single_poly_addr got %0h want 200040", bus.poly_addr); else passes++;
      wait_done(ok);
      checks++; if (ok !== 1'b1) $display("FAIL single_done_seen got %0b want 1", ok); else passes++;
      checks++; if (render_cnt - r0 !== 1) $display("FAIL single_render_count got %0d want 1", render_cnt - r0); else passes++;
      checks++; if (prim_count !== 16'd1) $display("FAIL single_prim_count got %0d want 1", prim_count); else passes++;
      checks++; if (error !== 1'b0) $display("FAIL single_error got %0b want 0", error); else passes++;
      @(negedge clock);
      checks++; if ({done, busy} !== 2'b00) $display("FAIL single_after_done got done=%0b busy=%0b want 0 0", done, busy); else passes++;
   endtask

   // Also holds start and injects stray poly_drawn outside DRAW.
   task automatic test_link();
      int r0;
      int f0;
      bit ok;
      mem.delete();
      mem[24'h1000] = 32'hE000_2000;
      mem[24'h2000] = 32'h8000_0004;
      mem[24'h2004] = 32'hF000_0000;
      ol_base      = 24'h1000;
      param_base   = 24'h200000;
      parser_delay = 5;
      r0 = render_cnt;
      f0 = fetch_q.size();
      @(negedge clock);
      start    = 1'b1;
      pd_extra = 1'b1;
      @(negedge clock);
      checks++; if (prim_count !== 16'd0) $display("FAIL link_prim_cleared got %0d want 0", prim_count); else passes++;
      @(negedge clock);
      @(negedge clock);
      checks++; if ({bus.vram_rd, bus.vram_addr} !== {1'b1, 24'h2000})
         $display("FAIL link_second_fetch got rd=%0b addr=%0h want rd=1 addr=2000", bus.vram_rd, bus.vram_addr); else passes++;
      start    = 1'b0;
      pd_extra = 1'b0;
      wait_done(ok);
      checks++; if (ok !== 1'b1) $display("FAIL link_done_seen got %0b want 1", ok); else passes++;
      checks++; if (fetch_q.size() - f0 !== 3) $display("FAIL link_fetch_count got %0d want 3", fetch_q.size() - f0); else passes++;
      if (fetch_q.size() - f0 == 3) begin
         checks++;
         if ({fetch_q[f0], fetch_q[f0+1], fetch_q[f0+2]} !== {24'h1000, 24'h2000, 24'h2004})
            $display("FAIL link_fetch_seq got %0h %0h %0h want 1000 2000 2004", fetch_q[f0], fetch_q[f0+1], fetch_q[f0+2]);
         else passes++;
      end
      checks++; if (render_cnt - r0 !== 1) $display("FAIL link_render_count got %0d want 1", render_cnt - r0); else passes++;
      checks++; if (last_poly !== 24'h200010) $display("FAIL link_poly_addr got %0h want 200010", last_poly); else passes++;
      checks++; if (last_opb !== 32'h8000_0004) $display("FAIL link_opb got %0h want 80000004", last_opb); else passes++;
      checks++; if (prim_count !== 16'd1) $display("FAIL link_prim_count got %0d want 1", prim_count); else passes++;
   endtask

   task automatic test_vram_mux();
      bit ok;
      load_list1();
      parser_delay      = 10;
      bus.isp_vram_rd   = 1'b1;
      bus.isp_vram_addr = 24'h200044;
      do_start();
      checks++; if ({bus.vram_rd, bus.vram_addr} !== {1'b1, 24'h1000})
         $display("FAIL mux_fetch_walker got rd=%0b addr=%0h want rd=1 addr=1000", bus.vram_rd, bus.vram_addr); else passes++;
      @(negedge clock);
      checks++; if (bus.vram_rd !== 1'b0) $display("FAIL mux_decode_rd got %0b want 0", bus.vram_rd); else passes++;
      wait_grant(ok);
      checks++; if (ok !== 1'b1) $display("FAIL mux_grant_seen got %0b want 1", ok); else passes++;
      checks++; if ({bus.vram_rd, bus.vram_addr} !== {1'b1, 24'h200044})
         $display("FAIL mux_draw got rd=%0b addr=%0h want rd=1 addr=200044", bus.vram_rd, bus.vram_addr); else passes++;
      ok = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clock);
         if (!bus.isp_grant) begin
            ok = 1'b1;
            break;
         end
      end
      checks++; if (ok !== 1'b1) $display("FAIL mux_release_seen got %0b want 1", ok); else passes++;
      checks++; if ({bus.vram_rd, bus.vram_addr} !== {1'b1, 24'h1004})
         $display("FAIL mux_next_fetch got rd=%0b addr=%0h want rd=1 addr=1004", bus.vram_rd, bus.vram_addr); else passes++;
      wait_done(ok);
      bus.isp_vram_rd = 1'b0;
      checks++; if ({ok, prim_count} !== {1'b1, 16'd1}) $display("FAIL mux_end got done=%0b prim=%0d want 1 1", ok, prim_count); else passes++;
   endtask

   task automatic test_timeout();
      int d;
      int r0;
      bit ok;
      load_list1();
      parser_delay = 0;
      r0 = render_cnt;
      do_start();
      wait_grant(ok);
      checks++; if (ok !== 1'b1) $display("FAIL tmo_grant_seen got %0b want 1", ok); else passes++;
      d = cyc;
      wait_done(ok);
      checks++; if (ok !== 1'b1) $display("FAIL tmo_done_seen got %0b want 1", ok); else passes++;
      checks++; if (cyc - d !== 16) $display("FAIL tmo_latency got %0d want 16", cyc - d); else passes++;
      checks++; if (error !== 1'b1) $display("FAIL tmo_error got %0b want 1", error); else passes++;
      checks++; if (prim_count !== 16'd0) $display("FAIL tmo_prim_count got %0d want 0", prim_count); else passes++;
      checks++; if (render_cnt - r0 !== 1) $display("FAIL tmo_render_count got %0d want 1", render_cnt - r0); else passes++;
   endtask

   // poly_drawn lands in the same cycle the timeout would fire.
   task automatic test_drawn_at_timeout();
      bit ok;
      load_list1();
      parser_delay = 16;
      do_start();
      checks++; if (error !== 1'b0) $display("FAIL edge_error_cleared got %0b want 0", error); else passes++;
      wait_done(ok);
      checks++; if (ok !== 1'b1) $display("FAIL edge_done_seen got %0b want 1", ok); else passes++;
      checks++; if (error !== 1'b0) $display("FAIL edge_error got %0b want 0", error); else passes++;
      checks++; if (prim_count !== 16'd1) $display("FAIL edge_prim_count got %0d want 1", prim_count); else passes++;
      checks++; if (fetch_q[$] !== 24'h1004) $display("FAIL edge_last_fetch got %0h want 1004", fetch_q[$]); else passes++;
   endtask

   task automatic test_max_entries();
      int f0;
      int r0;
      int bad;
      bit ok;
      mem.delete();
      mem[24'h1000] = 32'hE000_1000;
      ol_base = 24'h1000;
      f0 = fetch_q.size();
      r0 = render_cnt;
      do_start();
      wait_done(ok);
      checks++; if (ok !== 1'b1) $display("FAIL max_done_seen got %0b want 1", ok); else passes++;
      checks++; if (fetch_q.size() - f0 !== 8) $display("FAIL max_fetch_count got %0d want 8", fetch_q.size() - f0); else passes++;
      bad = 0;
      for (int i = f0; i < fetch_q.size(); i++) if (fetch_q[i] !== 24'h1000) bad++;
      checks++; if (bad !== 0) $display("FAIL max_fetch_addr got %0d wrong addresses want 0", bad); else passes++;
      checks++; if (error !== 1'b1) $display("FAIL max_error got %0b want 1", error); else passes++;
      checks++; if ({prim_count, render_cnt - r0 == 0} !== {16'd0, 1'b1})
         $display("FAIL max_no_prims got prim=%0d renders=%0d want 0 0", prim_count, render_cnt - r0); else passes++;
   endtask

   task automatic test_reset_mid_draw();
      int r0;
      bit ok;
      load_list1();
      parser_delay      = 0;
      bus.isp_vram_rd   = 1'b1;
      bus.isp_vram_addr = 24'h200044;
      do_start();
      wait_grant(ok);
      checks++; if (ok !== 1'b1) $display("FAIL rst_grant_seen got %0b want 1", ok); else passes++;
      reset = 1'b1;
      @(negedge clock);
      checks++; if ({busy, bus.isp_grant, bus.vram_rd, done} !== 4'b0000)
         $display("FAIL rst_outputs got busy=%0b grant=%0b rd=%0b done=%0b want all 0",
                  busy, bus.isp_grant, bus.vram_rd, done); else passes++;
      reset           = 1'b0;
      bus.isp_vram_rd = 1'b0;
      parser_delay    = 5;
      r0 = render_cnt;
      do_start();
      wait_done(ok);
      checks++; if (ok !== 1'b1) $display("FAIL rst_rewalk_done got %0b want 1", ok); else passes++;
      checks++; if ({prim_count, error} !== {16'd1, 1'b0})
         $display("FAIL rst_rewalk_status got prim=%0d err=%0b want 1 0", prim_count, error); else passes++;
      checks++; if (render_cnt - r0 !== 1) $display("FAIL rst_rewalk_renders got %0d want 1", render_cnt - r0); else passes++;
      checks++; if (last_poly !== 24'h200040) $display("FAIL rst_rewalk_poly got %0h want 200040", last_poly); else passes++;
   endtask

   initial begin
      reset             = 1'b1;
      start             = 1'b0;
      ol_base           = 24'h0;
      param_base        = 24'h0;
      parser_delay      = 0;
      pd_extra          = 1'b0;
      bus.isp_vram_rd   = 1'b0;
      bus.isp_vram_addr = 24'h0;
      bus.vram_din      = 32'h0;
      test_reset();
      test_single_prim();
      test_link();
      test_vram_mux();
      test_timeout();
      test_drawn_at_timeout();
      test_max_entries();
      test_reset_mid_draw();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ol_sequencer.md
# ol_sequencer

Object-list sequencer for the PVR ISP front end. Walks one tile's object list in VRAM from a base address. Decodes each entry as a primitive pointer, link or end-of-list. For each strip, triangle-array or quad-array entry it launches the ISP parser (`opb_word`, `poly_addr`, `render_poly`) and waits for `poly_drawn`. It owns the single VRAM read port and hands it to the parser only while a primitive is being parsed.

## Interface
Parameters:
- `MAX_ENTRIES`, 4096: decoded-entry limit per list (loop guard)
- `TIMEOUT`, 1024: max cycles waiting for `poly_drawn`

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `start`  in  1  begin walk; ignored while `busy`
- `ol_base`  in  24  byte address of first list word
- `param_base`  in  24  byte base of parameter buffer
- `busy`  out  1  walk in progress
- `done`  out  1  one-cycle pulse at walk end (normal or error)
- `error`  out  1  sticky; set on timeout or entry limit; cleared on `start`
- `prim_count`  out  16  primitives completed; cleared on `start`; saturates at 0xFFFF
- `vram_rd`  out  1  shared VRAM read strobe
- `vram_addr`  out  24  shared VRAM byte address
- `vram_din`  in  32  VRAM data, valid the cycle after `vram_rd`/`vram_addr`
- `isp_vram_rd`  in  1  parser read strobe
- `isp_vram_addr`  in  24  parser address
- `isp_grant`  out  1  parser owns VRAM port
- `opb_word`  out  32  current list entry to parser
- `poly_addr`  out  24  parameter address to parser
- `render_poly`  out  1  one-cycle launch pulse
- `poly_drawn`  in  1  parser completion pulse

## Operation
- Entry decode on `vram_din`:
  - bit31=0: triangle strip.
  - [31:29]=100: triangle array.
  - [31:29]=101: quad array.
  - [31:29]=111 with bit28=0: link.
  - [31:29]=111 with bit28=1: end of list.
  - [31:29]=110: reserved, skipped.
- Primitive address: `poly_addr` = (`param_base` + {[20:0],2'b00}) mod 2^24.
- Link target: {[23:2],2'b00}.
- States and transitions:
  - IDLE: `start` → FETCH. `cur`←`ol_base`, `error`/`prim_count`/entry counter cleared.
  - FETCH: `vram_rd`=1, `vram_addr`=`cur` → DECODE.
  - DECODE: data sampled, entry counter +1.
    - Primitive: latch `opb_word`, `poly_addr`; `cur`+=4 → ISSUE.
    - Link: `cur`←target → FETCH.
    - Reserved: `cur`+=4 → FETCH.
    - EOL → DONE.
    - If the counter reaches `MAX_ENTRIES` after the increment: `error`=1 → DONE. This overrides the decoded action.
  - ISSUE: `render_poly`=1 → DRAW. Timeout counter cleared.
  - DRAW: `isp_grant`=1. `poly_drawn` → `prim_count`+1 → FETCH. Timeout counter reaching `TIMEOUT` → `error`=1 → DONE.
  - DONE: `done`=1 → IDLE.
- VRAM mux (combinational on state):
  - In DRAW, `vram_rd`/`vram_addr` = `isp_vram_rd`/`isp_vram_addr`.
  - In FETCH, walker values.
  - Otherwise `vram_rd`=0, `vram_addr`=`cur`.
  - Parser strobes outside DRAW never reach the port; the parser may leave `isp_vram_rd` high after finishing.
- `opb_word`/`poly_addr` held stable from DECODE until the next primitive DECODE.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values: `busy` 0, `done` 0, `error` 0, `prim_count` 0, `render_poly` 0, `isp_grant` 0, `vram_rd` 0, `vram_addr` 0, `opb_word` 0, `poly_addr` 0. State is IDLE.
- Reset in any state returns to IDLE in the next cycle; no `done` pulse.
- `start` at cycle N: FETCH at N+1, DECODE at N+2, `render_poly` at N+3, DRAW from N+4.
- Link costs 2 cycles (FETCH+DECODE).
- `poly_drawn` at cycle M: FETCH of next entry at M+1.
- `poly_drawn` and timeout in the same cycle: `poly_drawn` wins.
- `poly_drawn` outside DRAW is ignored.
- `start` while busy is ignored.
- `cur` wraps modulo 2^24.

## Structure
- Package `pvr_ol_pkg`: state enum; opcode constants (STRIP bit31=0, TRI_ARRAY 3'b100, QUAD_ARRAY 3'b101, RESERVED 3'b110, LINK 3'b111); EOL bit 28; field ranges [20:0], [23:2].
- Sub-module `ol_entry_decode`: combinational entry classifier. It outputs kind, primitive address and link target.

## Test plan
- List at 0x1000 = {0x00000010, 0xF0000000}, `param_base`=0x200000, parser answers 5 cycles after launch → one `render_poly`, `poly_addr`=0x200040, `opb_word`=0x00000010; then `done`, `prim_count`=1, `error`=0.
- 0x1000 = 0xE0002000, 0x2000 = 0x80000004, 0x2004 = 0xF0000000 → FETCH address sequence 0x1000, 0x2000, 0x2004; array launched with `poly_addr` = `param_base`+0x10.
- During DRAW, `isp_vram_addr`=0x200044 with `isp_vram_rd`=1 → `vram_addr`=0x200044. In the next FETCH, with `isp_vram_rd` still 1, `vram_addr`=walker `cur`.
- `poly_drawn` never returned, `TIMEOUT`=16 → `error`=1 and `done` 16 cycles after DRAW entry; `prim_count`=0.
- `MAX_ENTRIES`=8, 0x1000 = 0xE0001000 (self-link) → exactly 8 FETCHes, then `error`=1, `done`.
- Reset asserted mid-DRAW → next cycle `busy`=0, `isp_grant`=0, `vram_rd`=0. A following `start` walks list 1 correctly.
